// File: rtl/cafeteira_serial_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cafeteira_serial_rx_fifo
// Description : UART receiver with configurable character format and parity
//               check, feeding a show-ahead receive FIFO with sticky line
//               error flags. Drained through a valid/read handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cafeteira_serial_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int DEPTH        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rxd,
  input  logic                   ler,
  input  logic                   limpa_erros,
  output logic [DATA_BITS-1:0]   dados,
  output logic                   pronto,
  output logic                   cheio,
  output logic [$clog2(DEPTH):0] contagem,
  output logic                   erro_paridade,
  output logic                   erro_quadro,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] c_cnt_mid  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   c_full     = (PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // Synchronizer
  logic r_meta;
  logic r_rxs;

  // Receiver
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;

  // FIFO
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;

  logic w_sample_last;
  logic w_par_bad;
  logic w_par_evt;
  logic w_frm_evt;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_ovf_evt;

  // Bring the asynchronous line into the clock domain; idles high out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= rxd;
      r_rxs  <= r_meta;
    end
  end

  assign w_sample_last = (r_cnt == c_cnt_last);

  // Even parity: data plus parity bit must have an even number of ones
  assign w_par_bad = (PARITY == 2) ? ~(^r_shift ^ r_rxs) : (^r_shift ^ r_rxs);

  assign w_par_evt = (r_state == S_PARITY) && w_sample_last && w_par_bad;
  assign w_frm_evt = (r_state == S_STOP) && w_sample_last && !r_rxs;
  assign w_push    = (r_state == S_STOP) && w_sample_last && r_rxs && !r_par_err;

  assign w_pop     = ler && pronto;
  assign w_wr      = w_push && (!cheio || w_pop);
  assign w_ovf_evt = w_push && cheio && !w_pop;

  // Character framing: find the start bit centre, then sample each bit one bit-time later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == c_cnt_mid) begin
            if (!r_rxs) begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_idx     <= '0;
              r_par_err <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_sample_last) begin
            r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
            r_cnt   <= '0;
            if (r_idx == c_idx_last) begin
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_sample_last) begin
            r_par_err <= w_par_bad;
            r_cnt     <= '0;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_sample_last) begin
            r_cnt   <= '0;
            r_state <= r_rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must not decode as a run of zero characters
          if (r_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_paridade <= 1'b0;
      erro_quadro   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      erro_paridade <= w_par_evt | (erro_paridade & ~limpa_erros);
      erro_quadro   <= w_frm_evt | (erro_quadro & ~limpa_erros);
      overflow      <= w_ovf_evt | (overflow & ~limpa_erros);
    end
  end

  // FIFO storage; contents are meaningless while empty, so no reset
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy; a push at full is only accepted alongside a pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dados    = r_mem[r_rd_ptr];
  assign contagem = r_count;
  assign pronto   = (r_count != '0);
  assign cheio    = (r_count == c_full);

endmodule
`default_nettype wire

// File: tb/tb_cafeteira_serial_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_cafeteira_serial_rx_fifo
// Description : Scoreboard bench for the serial receive FIFO. Characters are
//               framed from their bit-level definition; a queue holds the
//               characters the FIFO should deliver, a monitor checks reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cafeteira_serial_rx_fifo;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int PAR = 1;
  localparam int DEP = 4;
  localparam int FRAME_CYC = 11 * CPB;
  // Edge (counted from the start-bit edge) on which the stop bit is sampled:
  // 2 sync + 1 idle detect + 1 + CPB/2 start + 10 bit-times
  localparam int PUSH_EDGE = 4 + CPB / 2 + 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       ler = 1'b0;
  logic       limpa_erros = 1'b0;
  logic [7:0] dados;
  logic       pronto;
  logic       cheio;
  logic [2:0] contagem;
  logic       erro_paridade;
  logic       erro_quadro;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  bit exp_par = 1'b0;
  bit exp_frm = 1'b0;
  bit exp_ovf = 1'b0;
  bit rd_rand = 1'b0;
  bit rd_force = 1'b0;

  cafeteira_serial_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY      (PAR),
    .DEPTH       (DEP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rxd          (rxd),
    .ler          (ler),
    .limpa_erros  (limpa_erros),
    .dados        (dados),
    .pronto       (pronto),
    .cheio        (cheio),
    .contagem     (contagem),
    .erro_paridade(erro_paridade),
    .erro_quadro  (erro_quadro),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Read strobe driver: random reads, or forced by directed steps
  initial begin
    forever begin
      @(posedge clock);
      #2;
      ler = rd_rand ? 1'($urandom_range(0, 1)) : rd_force;
    end
  end

  // Monitor: every accepted read must deliver the oldest expected character
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset && ler && pronto) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL read_unexpected actual=%0h required=none", dados);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", {24'h0, dados}, {24'h0, e});
        end
      end
    end
  end

  // Serialize one frame: start, 8 data LSB first, even parity (optionally flipped), stop
  task automatic send(input logic [7:0] d, input bit flip, input bit stop,
                      input bit pop_at_push, input int ncyc);
    logic [10:0] fr;
    fr = {stop, (^d) ^ flip, d, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      rxd = fr[4'(c / CPB)];
      rd_force = pop_at_push && (c == PUSH_EDGE - 1);
    end
  endtask

  // Reference behaviour of one received character, then put it on the line
  task automatic rx_char(input logic [7:0] d, input bit flip, input bit stop, input bit pop);
    if (!flip && stop) begin
      if (exp_q.size() < DEP || pop) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    if (flip) exp_par = 1'b1;
    if (!stop) exp_frm = 1'b1;
    send(d, flip, stop, pop, FRAME_CYC);
  endtask

  task automatic chk_flags();
    chk("erro_paridade", {31'h0, erro_paridade}, {31'h0, exp_par});
    chk("erro_quadro", {31'h0, erro_quadro}, {31'h0, exp_frm});
    chk("overflow", {31'h0, overflow}, {31'h0, exp_ovf});
  endtask

  task automatic chk_level();
    chk("contagem", {29'h0, contagem}, 32'(exp_q.size()));
    chk("pronto", {31'h0, pronto}, {31'h0, exp_q.size() != 0});
    chk("cheio", {31'h0, cheio}, {31'h0, exp_q.size() == DEP});
  endtask

  task automatic clear_flags();
    @(posedge clock);
    #1 limpa_erros = 1'b1;
    @(posedge clock);
    #1 limpa_erros = 1'b0;
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1 rd_force = 1'b1;
    end
    @(posedge clock);
    #1 rd_force = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    int r;

    // Reset with idle line
    repeat (5) @(posedge clock);
    #1;
    chk_level();
    chk_flags();
    reset = 1'b1;
    repeat (3) @(posedge clock);

    // First character and single read
    rx_char(8'hA5, 1'b0, 1'b1, 1'b0);
    chk_level();
    chk("dados_head", {24'h0, dados}, 32'h0000_00A5);
    chk_flags();
    drain(1);
    chk_level();

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      rx_char(8'(i), 1'b0, 1'b1, 1'b0);
      if (i >= 4) begin
        chk_level();
        chk_flags();
      end
    end
    drain(6);
    chk_level();
    clear_flags();
    chk_flags();

    // Second fill, fifth character arrives together with a read
    for (int i = 0; i < 4; i++) rx_char(8'($urandom), 1'b0, 1'b1, 1'b0);
    chk_level();
    rx_char(8'($urandom), 1'b0, 1'b1, 1'b1);
    chk_level();
    chk_flags();
    drain(6);
    chk_level();

    // Parity error
    rx_char(8'h3C, 1'b1, 1'b1, 1'b0);
    chk_level();
    chk_flags();

    // Framing error followed by a long low: nothing must decode from the break
    rx_char(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (5 * CPB) @(posedge clock);
    #1;
    chk_level();
    chk_flags();
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge clock);
    #1;
    chk_level();
    clear_flags();
    chk_flags();
    rx_char(8'h81, 1'b0, 1'b1, 1'b0);
    chk_level();
    drain(2);

    // Short glitch on the line
    @(posedge clock);
    #1 rxd = 1'b0;
    repeat (4) @(posedge clock);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk_level();
    chk_flags();
    rx_char(8'h7E, 1'b0, 1'b1, 1'b0);
    chk_level();
    drain(2);

    // Randomized traffic with random reads and injected line errors
    rd_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      rx_char(d, r == 0, r != 1, 1'b0);
      if (r == 1) begin
        rxd = 1'b1;
        repeat (CPB) @(posedge clock);
        #1;
      end
      chk_flags();
      if (r >= 8) begin
        clear_flags();
        chk_flags();
      end
    end
    repeat (40) @(posedge clock);
    rd_rand = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_level();

    // Leave one character queued, then reset in the middle of a data bit
    rx_char(8'h11, 1'b0, 1'b1, 1'b0);
    send(8'hC3, 1'b0, 1'b1, 1'b0, 5 * CPB);
    #3 reset = 1'b0;
    rxd = 1'b1;
    exp_q.delete();
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovf = 1'b0;
    #1;
    chk_level();
    chk_flags();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2 * FRAME_CYC) @(posedge clock);
    #1;
    chk_level();

    // Clean character after reset
    rx_char(8'h5A, 1'b0, 1'b1, 1'b0);
    chk_level();
    chk("dados_after_reset", {24'h0, dados}, 32'h0000_005A);
    chk_flags();
    drain(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
